// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared widths, instruction field positions and ID/EX payload
package processor_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [DATA_W-1:0]    rd1;
        logic [DATA_W-1:0]    rd2;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    signImm;
        logic                 valid;
    } idEx_t;

    function automatic logic [DATA_W-1:0] signExtend(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - 32x32 register file, bypassed combinational reads, one write port
module gpr_file
    import processor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] readAddr1,
    input  logic [REG_IDX_W-1:0] readAddr2,
    output logic [DATA_W-1:0]    readData1,
    output logic [DATA_W-1:0]    readData2,
    input  logic                 writeEn,
    input  logic [REG_IDX_W-1:0] writeAddr,
    input  logic [DATA_W-1:0]    writeData
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (writeEn && writeAddr != '0) begin
            mem[writeAddr] <= writeData;
        end
    end

    // Write-through so a writeback in this cycle is seen by decode in the same cycle.
    assign readData1 = (readAddr1 == '0) ? '0 :
                       (writeEn && writeAddr == readAddr1) ? writeData : mem[readAddr1];
    assign readData2 = (readAddr2 == '0) ? '0 :
                       (writeEn && writeAddr == readAddr2) ? writeData : mem[readAddr2];

endmodule

// File: rtl/operand_read_stage.sv
// rtl/operand_read_stage.sv - IF/ID register, register file reads, branch resolve, ID/EX register
module operand_read_stage
    import processor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    instrF,
    input  logic [DATA_W-1:0]    pcPlus4F,
    input  logic                 stallD,
    input  logic                 flushD,
    input  logic                 flushE,
    input  logic                 regWriteW,
    input  logic [REG_IDX_W-1:0] writeRegW,
    input  logic [DATA_W-1:0]    resultW,
    output logic                 equalD,
    output logic [DATA_W-1:0]    pcBranchD,
    output logic [REG_IDX_W-1:0] rsD,
    output logic [REG_IDX_W-1:0] rtD,
    output logic [DATA_W-1:0]    rd1E,
    output logic [DATA_W-1:0]    rd2E,
    output logic [REG_IDX_W-1:0] rsE,
    output logic [REG_IDX_W-1:0] rtE,
    output logic [REG_IDX_W-1:0] rdE,
    output logic [DATA_W-1:0]    signImmE,
    output logic                 validE
);

    logic [DATA_W-1:0] instrD;
    logic [DATA_W-1:0] pcPlus4D;
    logic [DATA_W-1:0] rd1D;
    logic [DATA_W-1:0] rd2D;
    logic [DATA_W-1:0] signImmD;
    logic [5:0]        unusedOpcode;
    idEx_t             idExNext;
    idEx_t             idExQ;

    // Stall wins over flush so a held instruction is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrD   <= '0;
            pcPlus4D <= '0;
        end else if (!stallD) begin
            if (flushD) begin
                instrD   <= '0;
                pcPlus4D <= '0;
            end else begin
                instrD   <= instrF;
                pcPlus4D <= pcPlus4F;
            end
        end
    end

    assign rsD          = instrD[RS_HI:RS_LO];
    assign rtD          = instrD[RT_HI:RT_LO];
    assign signImmD     = signExtend(instrD[IMM_HI:IMM_LO]);
    assign unusedOpcode = instrD[31:26];

    gpr_file u_gprFile (
        .clk       (clk),
        .rst       (rst),
        .readAddr1 (rsD),
        .readAddr2 (rtD),
        .readData1 (rd1D),
        .readData2 (rd2D),
        .writeEn   (regWriteW),
        .writeAddr (writeRegW),
        .writeData (resultW)
    );

    assign equalD    = (rd1D == rd2D);
    assign pcBranchD = pcPlus4D + (signImmD << 2);

    always_comb begin
        idExNext         = '0;
        idExNext.rd1     = rd1D;
        idExNext.rd2     = rd2D;
        idExNext.rs      = rsD;
        idExNext.rt      = rtD;
        idExNext.rd      = instrD[RD_HI:RD_LO];
        idExNext.signImm = signImmD;
        idExNext.valid   = 1'b1;
    end

    // flushE is independent of stallD: a load-use bubble enters execute while decode holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idExQ <= '0;
        end else if (flushE) begin
            idExQ <= '0;
        end else begin
            idExQ <= idExNext;
        end
    end

    assign rd1E     = idExQ.rd1;
    assign rd2E     = idExQ.rd2;
    assign rsE      = idExQ.rs;
    assign rtE      = idExQ.rt;
    assign rdE      = idExQ.rd;
    assign signImmE = idExQ.signImm;
    assign validE   = idExQ.valid;

endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Decode-side partner of the writeback stage. Holds the IF/ID pipeline register and the 32x32 general-purpose register file. The file's single write port is driven by the writeback stage (regWriteW/writeRegW/resultW), and two read ports feed the decode operands. The block also resolves branch equality and target in decode and registers everything into the ID/EX pipeline register for the execute stage.

## Interface
- No parameters. Data width is fixed at 32, register index at 5.
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- instrF  in  32  fetched instruction
- pcPlus4F  in  32  fetch PC+4
- stallD  in  1  hold IF/ID register
- flushD  in  1  clear IF/ID register (taken branch)
- flushE  in  1  load bubble into ID/EX register
- regWriteW  in  1  writeback write enable
- writeRegW  in  5  writeback destination index
- resultW  in  32  writeback data
- equalD  out  1  rd1D == rd2D (bypassed values), combinational
- pcBranchD  out  32  pcPlus4D + (signImmD << 2), combinational
- rsD, rtD  out  5  instrD[25:21], instrD[20:16] for the hazard unit
- rd1E, rd2E  out  32  registered operand values
- rsE, rtE, rdE  out  5  registered instrD[25:21], [20:16], [15:11]
- signImmE  out  32  registered sign-extended instrD[15:0]
- validE  out  1  0 = bubble in execute

## Operation
- IF/ID register (instrD, pcPlus4D) is updated on every posedge with this priority: rst > stallD (hold) > flushD (clear to 0) > load instrF/pcPlus4F. When stallD and flushD are asserted together, the register holds.
- Register file:
  - Write: on posedge when regWriteW=1 and writeRegW!=0, mem[writeRegW] <= resultW.
  - Register 0 always reads as 0 and is never written.
- Read ports are combinational with write-through bypass:
  - rd1D = (rsD==0) ? 0 : (regWriteW && writeRegW==rsD) ? resultW : mem[rsD]. rd2D is the same with rtD.
  - As a result, a value written in cycle N is visible to a decode in cycle N with no extra stall.
- equalD and pcBranchD use the bypassed rd1D/rd2D and pcPlus4D. Add modulo 2^32; carry is dropped.
- ID/EX register update priority: rst > flushE (all fields 0, validE=0) > load decoded fields with validE=1.
  - flushE is honoured even while stallD=1; this is the load-use case, which inserts a bubble while decode holds.
  - A flushD in the same cycle does not affect ID/EX, which captures the instruction currently in decode.

## Timing
- Reset, asynchronous: instrD, pcPlus4D, all ID/EX outputs and validE = 0, all 32 registers = 0. The combinational outputs follow from those values: equalD=1, pcBranchD=0, rsD=rtD=0.
- Reset is effective immediately on assertion, mid-instruction included. Deassertion is assumed synchronous to clk upstream.
- Latency: instrF to instrD is 1 cycle; instrD to the E outputs is 1 cycle.
- Write/read collision in one cycle: the reader sees resultW combinationally; the array is updated at the edge.
- No handshake. stallD and flush are level-sampled at each posedge.

## Structure
- Shared package (processor pkg): DATA_W=32, REG_IDX_W=5, NUM_REGS=32, the instruction field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO, IMM_HI/LO), and a struct for the ID/EX payload (rd1, rd2, rs, rt, rd, signImm, valid).
- One sub-module: gpr_file (2 combinational bypassed read ports, 1 sync write port, async clear), instantiated once. Pipeline registers and branch logic stay in the top.

## Test plan
- Reset mid-run: load registers, assert rst between edges -> all outputs and validE go to 0 immediately; reading r5 afterwards returns 0.
- Write then read: write r5=0xDEADBEEF in cycle N, decode with rs=5 in cycle N+1 -> rd1E=0xDEADBEEF one cycle later. Same-cycle bypass: write r7=0x12345678 while instrD has rt=7 -> rd2E=0x12345678.
- r0 protection: regWriteW=1, writeRegW=0, resultW=0xFFFFFFFF -> rs=0 reads 0, both same-cycle and later.
- Branch: r1=r2=0x10, pcPlus4D=0x100, imm=0xFFFF -> equalD=1, pcBranchD=0xFC. With r2=0x11 -> equalD=0.
- Stall/flush priority: stallD=1 and flushD=1 -> instrD holds its old value. stallD=1 and flushE=1 -> next cycle validE=0, all E fields 0, instrD unchanged. Then stallD=0 -> the held instruction reaches E with validE=1.
- flushD alone: taken branch -> the next instrD is 0x00000000 (nop) and the following E stage carries an all-zero instruction with validE=1.
